max10nios_busy_conditioner: RTL and testbench



---
 rtl/max10nios_busy_pkg.sv | 20 ++
 rtl/max10nios_sync_filter.sv | 98 +++++++++
 rtl/max10nios_busy_conditioner.sv | 169 ++++++++++++++++
 tb/tb_max10nios_busy_conditioner.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/max10nios_busy_pkg.sv
// ----------------------------------------------------------------------------
// max10nios_busy_pkg
// Shared types and helpers for the busy-line conditioning stage.
//   busy_state_e : supervisor FSM states (IDLE, BUSY, TIMEOUT)
//   cnt_width()  : counter width for a modulus n (clog2, never below 1)
// ----------------------------------------------------------------------------
package max10nios_busy_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        TIMEOUT = 2'd2
    } busy_state_e;

    // Bits needed to count 0..n-1; degenerate moduli still get one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage : max10nios_busy_pkg

// File: rtl/max10nios_sync_filter.sv
// ----------------------------------------------------------------------------
// max10nios_sync_filter
// Synchronizes the asynchronous busy line, debounces it with a
// consecutive-difference counter and produces registered edge pulses.
//
// Parameters:
//   SYNC_STAGES   : synchronizer depth (>= 2)
//   FILTER_CYCLES : consecutive differing synchronized cycles needed to flip
//
// Ports:
//   clk          : system clock, rising edge
//   reset_n      : asynchronous active-low reset
//   busy_raw_i   : raw busy line, asynchronous to clk
//   busy_o       : filtered busy level (registered)
//   rise_o       : one-cycle pulse, aligned with busy_o going 0->1
//   fall_o       : one-cycle pulse, aligned with busy_o going 1->0
//   flip_rise_c  : combinational, busy_o rises on the coming edge
//   flip_fall_c  : combinational, busy_o falls on the coming edge
// ----------------------------------------------------------------------------
module max10nios_sync_filter
    import max10nios_busy_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic busy_raw_i,
    output logic busy_o,
    output logic rise_o,
    output logic fall_o,
    output logic flip_rise_c,
    output logic flip_fall_c
);

    localparam int unsigned CW = cnt_width(FILTER_CYCLES);
    localparam int unsigned CNT_LAST_INT = (FILTER_CYCLES == 0) ? 0 : FILTER_CYCLES - 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_LAST_INT);

    logic [SYNC_STAGES-1:0] sync_chain_q;
    logic                   sync_lvl;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   busy_q;
    logic                   busy_d;
    logic                   rise_q;
    logic                   fall_q;
    logic                   flip;

    // Synchronizer chain; the last stage is the only one the filter looks at.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_chain_q <= '0;
        end else begin
            sync_chain_q <= {sync_chain_q[SYNC_STAGES-2:0], busy_raw_i};
        end
    end

    assign sync_lvl = sync_chain_q[SYNC_STAGES-1];

    // Filter: count cycles of disagreement, flip after FILTER_CYCLES of them.
    always_comb begin
        cnt_d  = '0;
        busy_d = busy_q;
        flip   = 1'b0;
        if (sync_lvl != busy_q) begin
            if (cnt_q == CNT_LAST) begin
                flip   = 1'b1;
                busy_d = sync_lvl;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign flip_rise_c = flip & sync_lvl;
    assign flip_fall_c = flip & ~sync_lvl;

    // Filtered level and edge pulses share the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            rise_q <= flip_rise_c;
            fall_q <= flip_fall_c;
        end
    end

    assign busy_o = busy_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule : max10nios_sync_filter

// File: rtl/max10nios_busy_conditioner.sv
// ----------------------------------------------------------------------------
// max10nios_busy_conditioner
// Conditions the external busy line for the PIO in_port: synchronize and
// filter it, time how long it stays busy, raise a sticky stuck-busy flag and
// emit rise/fall pulses.
//
// Build option: define BUSY_COND_IRQ_EN to get a sticky interrupt that sets on
// busy_fall or on entry to TIMEOUT and clears on irq_ack. Without it irq is
// tied low and irq_ack is ignored.
//
// Parameters:
//   SYNC_STAGES    : synchronizer depth (>= 2)
//   FILTER_CYCLES  : stable cycles required before busy_out changes (>= 1)
//   TIMEOUT_CYCLES : continuous busy cycles before timeout; 0 disables it
//
// Ports:
//   clk          : system clock, rising edge
//   reset_n      : asynchronous active-low reset
//   busy_raw     : raw busy line, asynchronous to clk
//   timeout_clr  : pulse, clears a sticky timeout
//   irq_ack      : pulse, clears irq (option only)
//   busy_out     : filtered busy level
//   busy_timeout : sticky stuck-busy flag
//   busy_rise    : one-cycle pulse on busy_out 0->1
//   busy_fall    : one-cycle pulse on busy_out 1->0
//   irq          : interrupt request (option only)
// ----------------------------------------------------------------------------
module max10nios_busy_conditioner
    import max10nios_busy_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic busy_raw,
    input  logic timeout_clr,
    input  logic irq_ack,
    output logic busy_out,
    output logic busy_timeout,
    output logic busy_rise,
    output logic busy_fall,
    output logic irq
);

    localparam int unsigned TW          = cnt_width(TIMEOUT_CYCLES);
    localparam int unsigned T_LAST_INT  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [TW-1:0] T_LAST    = TW'(T_LAST_INT);
    localparam logic          TO_EN     = (TIMEOUT_CYCLES != 0);

    busy_state_e   state_q;
    busy_state_e   state_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          timeout_q;
    logic          filt_busy;
    logic          rise_c;
    logic          fall_c;
    logic          busy_next_c;

    max10nios_sync_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_sync_filter (
        .clk         (clk),
        .reset_n     (reset_n),
        .busy_raw_i  (busy_raw),
        .busy_o      (filt_busy),
        .rise_o      (busy_rise),
        .fall_o      (busy_fall),
        .flip_rise_c (rise_c),
        .flip_fall_c (fall_c)
    );

    // Level busy_out will hold after the coming edge.
    assign busy_next_c = (filt_busy & ~fall_c) | rise_c;

    // Supervisor state register, timer and sticky timeout flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            timeout_q <= (state_d == TIMEOUT);
        end
    end

    // Next state: the FSM moves on the same edge busy_out changes, so the
    // timer starts at 0 in the cycle busy_out first reads 1.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            IDLE: begin
                if (rise_c) begin
                    state_d = BUSY;
                    timer_d = '0;
                end
            end
            BUSY: begin
                if (timer_q != '1) begin
                    timer_d = timer_q + TW'(1);
                end
                // A fall on the expiry cycle takes priority over the timeout.
                if (fall_c) begin
                    state_d = IDLE;
                end else if (TO_EN && (timer_q == T_LAST)) begin
                    state_d = TIMEOUT;
                end
            end
            TIMEOUT: begin
                // Resume on the level busy_out is about to show, so a clear
                // coinciding with a filtered fall never parks us in BUSY.
                if (timeout_clr) begin
                    if (busy_next_c) begin
                        state_d = BUSY;
                        timer_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_out     = filt_busy;
    assign busy_timeout = timeout_q;

`ifdef BUSY_COND_IRQ_EN
    logic irq_q;
    logic irq_d;
    logic enter_to_c;

    assign enter_to_c = (state_d == TIMEOUT) && (state_q != TIMEOUT);

    // Sticky interrupt; a set condition beats a simultaneous acknowledge.
    always_comb begin
        irq_d = irq_q;
        if (irq_ack) begin
            irq_d = 1'b0;
        end
        if (fall_c || enter_to_c) begin
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    logic unused_irq_ack;
    assign unused_irq_ack = irq_ack;
    assign irq            = 1'b0;
`endif

endmodule : max10nios_busy_conditioner

// File: tb/tb_max10nios_busy_conditioner.sv
// ----------------------------------------------------------------------------
// tb_max10nios_busy_conditioner
// Self-checking bench: per-cycle vector table, hand-written corner sequences
// and randomized traffic against a behavioural model.
// ----------------------------------------------------------------------------
module tb_max10nios_busy_conditioner;

    localparam int unsigned SYNC = 2;
    localparam int unsigned FILT = 4;
    localparam int unsigned TOC  = 10;
`ifdef BUSY_COND_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic busy_raw;
    logic timeout_clr;
    logic irq_ack;
    logic busy_out;
    logic busy_timeout;
    logic busy_rise;
    logic busy_fall;
    logic irq;

    int total = 0;
    int bad   = 0;

    max10nios_busy_conditioner #(
        .SYNC_STAGES    (SYNC),
        .FILTER_CYCLES  (FILT),
        .TIMEOUT_CYCLES (TOC)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .busy_raw     (busy_raw),
        .timeout_clr  (timeout_clr),
        .irq_ack      (irq_ack),
        .busy_out     (busy_out),
        .busy_timeout (busy_timeout),
        .busy_rise    (busy_rise),
        .busy_fall    (busy_fall),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct packed {
        logic raw;
        logic clr;
        logic ack;
        logic out;
        logic to;
        logic rise;
        logic fall;
        logic irq;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input logic raw, input logic clr, input logic ack,
                       input logic out, input logic to, input logic rise,
                       input logic fall, input logic irqv);
        vec_t v;
        v.raw = raw; v.clr = clr; v.ack = ack; v.out = out;
        v.to = to; v.rise = rise; v.fall = fall; v.irq = irqv;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0b want=%0b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic out, input logic to,
                           input logic rise, input logic fall, input logic irqv);
        chk({tag, ".busy_out"},     busy_out,     out);
        chk({tag, ".busy_timeout"}, busy_timeout, to);
        chk({tag, ".busy_rise"},    busy_rise,    rise);
        chk({tag, ".busy_fall"},    busy_fall,    fall);
        chk({tag, ".irq"},          irq,          irqv & IRQ_EN);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    logic m_syncq[$];
    logic m_win[$];
    logic m_out, m_to, m_irq, m_rise, m_fall;
    int   m_arm;
    int   m_n;

    task automatic model_reset();
        m_syncq.delete();
        m_win.delete();
        for (int k = 0; k < int'(SYNC); k++) m_syncq.push_back(1'b0);
        for (int k = 0; k < int'(FILT); k++) m_win.push_back(1'b0);
        m_out = 0; m_to = 0; m_irq = 0; m_rise = 0; m_fall = 0;
        m_arm = -1; m_n = 0;
    endtask

    // busy_out flips when the last FILT synchronized samples all disagree
    // with it; timeout fires TOC edges after the busy period began.
    task automatic model_edge(input logic raw, input logic clr, input logic ack);
        logic s;
        logic all_diff;
        logic enter;
        s = m_syncq.pop_front();
        m_syncq.push_back(raw);
        m_win.push_back(s);
        void'(m_win.pop_front());
        all_diff = 1'b1;
        foreach (m_win[k]) if (m_win[k] == m_out) all_diff = 1'b0;
        m_n++;
        m_rise = all_diff && !m_out;
        m_fall = all_diff && m_out;
        if (all_diff) m_out = !m_out;
        enter = 1'b0;
        if (m_to) begin
            if (clr) begin
                m_to  = 1'b0;
                m_arm = m_out ? m_n : -1;
            end
        end else if (m_rise) begin
            m_arm = m_n;
        end else if (m_fall) begin
            m_arm = -1;
        end else if (m_arm >= 0 && m_n == m_arm + int'(TOC)) begin
            m_to  = 1'b1;
            m_arm = -1;
            enter = 1'b1;
        end
        if (IRQ_EN) begin
            if (m_fall || enter) m_irq = 1'b1;
            else if (ack)        m_irq = 1'b0;
        end
    endtask

    task automatic do_reset(input string tag);
        reset_n     = 1'b0;
        busy_raw    = 1'b0;
        timeout_clr = 1'b0;
        irq_ack     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_all({tag, ".rst"}, 0, 0, 0, 0, 0);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        // Scenario table: glitch, clean rise, timeout, clear, re-expiry,
        // fall during TIMEOUT with ack colliding with fall, ack alone.
        add(3,  1,0,0, 0,0,0,0,0);
        add(8,  0,0,0, 0,0,0,0,0);
        add(5,  1,0,0, 0,0,0,0,0);
        add(1,  1,0,0, 1,0,1,0,0);   // 6th edge: rise
        add(9,  1,0,0, 1,0,0,0,0);
        add(3,  1,0,0, 1,1,0,0,1);   // 10 edges after rise: timeout
        add(1,  1,1,0, 1,0,0,0,1);   // clear while busy
        add(9,  1,0,0, 1,0,0,0,1);
        add(1,  1,0,0, 1,1,0,0,1);   // re-expiry 10 edges after clear
        add(5,  0,0,0, 1,1,0,0,1);
        add(1,  0,0,1, 0,1,0,1,1);   // fall + ack together: irq stays
        add(1,  0,1,0, 0,0,0,0,1);   // clear while idle level
        add(1,  0,0,1, 0,0,0,0,0);   // ack alone drops irq
        add(3,  0,1,0, 0,0,0,0,0);   // clear outside TIMEOUT ignored

        do_reset("tbl");
        for (int i = 0; i < tbl.size(); i++) begin
            busy_raw    = tbl[i].raw;
            timeout_clr = tbl[i].clr;
            irq_ack     = tbl[i].ack;
            step();
            chk_all($sformatf("tbl[%0d]", i), tbl[i].out, tbl[i].to,
                    tbl[i].rise, tbl[i].fall, tbl[i].irq);
        end
        timeout_clr = 1'b0;
        irq_ack     = 1'b0;

        // Filtered fall lands on the timer-expiry edge.
        do_reset("s4");
        busy_raw = 1'b1;
        repeat (10) step();
        busy_raw = 1'b0;
        repeat (5) step();
        chk_all("s4.pre", 1, 0, 0, 0, 0);
        step();
        chk_all("s4.fall", 0, 0, 0, 1, 1);
        repeat (12) step();
        chk_all("s4.after", 0, 0, 0, 0, 1);

        // Asynchronous reset mid-BUSY, then re-acquire.
        do_reset("s5");
        busy_raw = 1'b1;
        repeat (8) step();
        chk_all("s5.busy", 1, 0, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all("s5.async", 0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        repeat (5) step();
        chk_all("s5.wait", 0, 0, 0, 0, 0);
        step();
        chk_all("s5.reacq", 1, 0, 1, 0, 0);

        // Randomized traffic against the model.
        do_reset("rnd");
        begin
            int run;
            logic lvl;
            run = 0;
            lvl = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if (run == 0) begin
                    lvl = ~lvl;
                    run = ($urandom_range(0, 7) == 0) ? int'($urandom_range(12, 40))
                                                      : int'($urandom_range(1, 8));
                end
                run--;
                busy_raw    = lvl;
                timeout_clr = ($urandom_range(0, 15) == 0);
                irq_ack     = ($urandom_range(0, 7) == 0);
                model_edge(busy_raw, timeout_clr, irq_ack);
                step();
                chk_all($sformatf("rnd[%0d]", i), m_out, m_to, m_rise, m_fall, m_irq);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_max10nios_busy_conditioner
